axi4sram_rw_arb: RTL and testbench

AXI4SRAM_RW_ARB -- requirements
Module: axi4sram_rw_arb

---
 rtl/axi4sram_rw_arb.sv | 131 +++++++++++++
 tb/tb_axi4sram_rw_arb.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/axi4sram_rw_arb.sv
// Single-port SRAM arbiter for an AXI4 slave. It alternates whole write and read
// bursts, counts beats against the captured length and returns the B response.
module axi4sram_rw_arb #(
  parameter int AXI4_IDWIDTH = 4,
  parameter bit WR_FIRST     = 1'b1
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    AWVALID_S,
  input  logic [7:0]              AWLEN_S,
  input  logic [AXI4_IDWIDTH-1:0] AWID_S,
  input  logic                    ARVALID_S,
  input  logic [7:0]              ARLEN_S,
  input  logic [AXI4_IDWIDTH-1:0] ARID_S,
  input  logic                    wr_beat,
  input  logic                    wr_last,
  input  logic                    rd_beat,
  input  logic                    BREADY_S,
  output logic                    awready_mc,
  output logic                    arready_mc,
  output logic                    waddrchset_mc,
  output logic                    raddrchset_mc,
  output logic                    wr_gnt,
  output logic                    rd_gnt,
  output logic                    bvalid_mc,
  output logic [AXI4_IDWIDTH-1:0] bid_mc,
  output logic [1:0]              bresp_mc,
  output logic [AXI4_IDWIDTH-1:0] rid_mc,
  output logic                    len_err
);

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA
  } state_e;

  state_e                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [7:0]              len_q, len_d;
  logic [AXI4_IDWIDTH-1:0] bid_q, bid_d;
  logic [AXI4_IDWIDTH-1:0] rid_q, rid_d;
  logic                    last_wr_q, last_wr_d;
  logic                    len_err_q, len_err_d;
  logic                    cnt_hit;

  assign cnt_hit = (cnt_q == len_q);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      bid_q     <= '0;
      rid_q     <= '0;
      last_wr_q <= ~WR_FIRST;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      bid_q     <= bid_d;
      rid_q     <= rid_d;
      last_wr_q <= last_wr_d;
      len_err_q <= len_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    bid_d     = bid_q;
    rid_d     = rid_q;
    last_wr_d = last_wr_q;
    len_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        // On a tie the channel not served last wins.
        if (AWVALID_S && (!ARVALID_S || !last_wr_q)) begin
          state_d   = WR_ADDR;
          last_wr_d = 1'b1;
        end else if (ARVALID_S) begin
          state_d   = RD_ADDR;
          last_wr_d = 1'b0;
        end
      end
      WR_ADDR: begin
        len_d   = AWLEN_S;
        bid_d   = AWID_S;
        cnt_d   = '0;
        state_d = WR_DATA;
      end
      WR_DATA: begin
        if (wr_beat) begin
          cnt_d = cnt_q + 8'd1;
          // The count, not WLAST, ends the burst; a disagreement is only flagged.
          len_err_d = wr_last ^ cnt_hit;
          if (cnt_hit) state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        if (BREADY_S) state_d = IDLE;
      end
      RD_ADDR: begin
        len_d   = ARLEN_S;
        rid_d   = ARID_S;
        cnt_d   = '0;
        state_d = RD_DATA;
      end
      RD_DATA: begin
        if (rd_beat) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_hit) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign awready_mc    = (state_q == WR_ADDR);
  assign waddrchset_mc = (state_q == WR_ADDR);
  assign arready_mc    = (state_q == RD_ADDR);
  assign raddrchset_mc = (state_q == RD_ADDR);
  assign wr_gnt        = (state_q == WR_DATA);
  assign rd_gnt        = (state_q == RD_DATA);
  assign bvalid_mc     = (state_q == WR_RESP);
  assign bresp_mc      = 2'b00;
  assign bid_mc        = bid_q;
  assign rid_mc        = rid_q;
  assign len_err       = len_err_q;

endmodule

// File: tb/tb_axi4sram_rw_arb.sv
// Directed/randomized bench for axi4sram_rw_arb. Expected behaviour comes from a
// transaction-level timeline: address cycle, L+1 granted beats, response, idle.
module tb_axi4sram_rw_arb;
  logic       ACLK = 1'b0;
  logic       ARESETN;
  logic       AWVALID_S, ARVALID_S;
  logic [7:0] AWLEN_S, ARLEN_S;
  logic [3:0] AWID_S, ARID_S;
  logic       wr_beat, wr_last, rd_beat, BREADY_S;
  logic       awready_mc, arready_mc, waddrchset_mc, raddrchset_mc;
  logic       wr_gnt, rd_gnt, bvalid_mc, len_err;
  logic [3:0] bid_mc, rid_mc;
  logic [1:0] bresp_mc;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 ACLK = ~ACLK;

  axi4sram_rw_arb #(.AXI4_IDWIDTH(4), .WR_FIRST(1'b1)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .AWVALID_S(AWVALID_S), .AWLEN_S(AWLEN_S), .AWID_S(AWID_S),
    .ARVALID_S(ARVALID_S), .ARLEN_S(ARLEN_S), .ARID_S(ARID_S),
    .wr_beat(wr_beat), .wr_last(wr_last), .rd_beat(rd_beat), .BREADY_S(BREADY_S),
    .awready_mc(awready_mc), .arready_mc(arready_mc),
    .waddrchset_mc(waddrchset_mc), .raddrchset_mc(raddrchset_mc),
    .wr_gnt(wr_gnt), .rd_gnt(rd_gnt), .bvalid_mc(bvalid_mc),
    .bid_mc(bid_mc), .bresp_mc(bresp_mc), .rid_mc(rid_mc), .len_err(len_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // All strobes/grants low; IDs are not part of this.
  task automatic chk_idle(input string tag);
    chk(tag, 32'({awready_mc, arready_mc, waddrchset_mc, raddrchset_mc,
                  wr_gnt, rd_gnt, bvalid_mc, bresp_mc, len_err}), 32'd0);
  endtask

  task automatic clr_inputs();
    AWVALID_S = 0; ARVALID_S = 0; AWLEN_S = 0; ARLEN_S = 0; AWID_S = 0; ARID_S = 0;
    wr_beat = 0; wr_last = 0; rd_beat = 0; BREADY_S = 0;
  endtask

  task automatic do_reset();
    ARESETN = 1'b0;
    clr_inputs();
    repeat (2) @(negedge ACLK);
    chk_idle("reset_outputs");
    chk("reset_ids", 32'({bid_mc, rid_mc}), 32'd0);
    ARESETN = 1'b1;
  endtask

  // Write burst of len+1 beats; mm = beat index whose WLAST is wrong (-1: none).
  task automatic do_write(input logic [3:0] id, input logic [7:0] len, input int bdly,
                          input int mm, input int gapmax);
    int b, cyc;
    logic perr;
    AWVALID_S = 1; AWLEN_S = len; AWID_S = id;
    @(negedge ACLK);
    chk("w_awready", 32'({awready_mc, waddrchset_mc, wr_gnt, rd_gnt}), 32'b1100);
    AWVALID_S = 0;
    b = 0; cyc = 0; perr = 0;
    while (b <= int'(len)) begin
      @(negedge ACLK);
      chk("w_gnt", 32'({wr_gnt, rd_gnt, bvalid_mc}), 32'b100);
      chk("w_len_err", 32'(len_err), 32'(perr));
      perr = 0; cyc++;
      rd_beat = 1'($urandom_range(0, 1));
      if (gapmax == 0 || cyc > 1000 || $urandom_range(0, gapmax) == 0) begin
        wr_beat = 1;
        wr_last = (b == int'(len)) ^ (b == mm);
        perr    = (b == mm);
        b++;
      end else begin
        wr_beat = 0;
        wr_last = 0;
      end
    end
    for (int k = 0; k <= bdly; k++) begin
      @(negedge ACLK);
      wr_beat = 0; wr_last = 0; rd_beat = 0;
      chk("w_bvalid", 32'({bvalid_mc, wr_gnt, bresp_mc}), 32'b1000);
      chk("w_bid", 32'(bid_mc), 32'(id));
      chk("w_resp_len_err", 32'(len_err), 32'(perr));
      perr = 0;
      BREADY_S = (k == bdly);
    end
    @(negedge ACLK);
    BREADY_S = 0;
    chk_idle("w_back_idle");
  endtask

  // Read burst of len+1 beats; abort >= 0 resets the DUT during that beat.
  task automatic do_read(input logic [3:0] id, input logic [7:0] len, input int abort);
    int b;
    ARVALID_S = 1; ARLEN_S = len; ARID_S = id;
    @(negedge ACLK);
    chk("r_arready", 32'({arready_mc, raddrchset_mc, rd_gnt, wr_gnt}), 32'b1100);
    ARVALID_S = 0;
    b = 0;
    while (b <= int'(len)) begin
      @(negedge ACLK);
      chk("r_gnt", 32'({rd_gnt, wr_gnt}), 32'b10);
      chk("r_rid", 32'(rid_mc), 32'(id));
      wr_beat = 1'($urandom_range(0, 1));
      wr_last = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) != 0) begin
        rd_beat = 1;
        if (b == abort) begin
          #2 ARESETN = 1'b0;
          #1;
          chk("abort_rd_gnt", 32'(rd_gnt), 32'd0);
          chk_idle("abort_outputs");
          chk("abort_ids", 32'({bid_mc, rid_mc}), 32'd0);
          clr_inputs();
          @(negedge ACLK);
          chk_idle("abort_held");
          ARESETN = 1'b1;
          return;
        end
        b++;
      end else begin
        rd_beat = 0;
      end
    end
    @(negedge ACLK);
    rd_beat = 0; wr_beat = 0; wr_last = 0;
    chk_idle("r_back_idle");
    chk("r_rid_hold", 32'(rid_mc), 32'(id));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] trace[$];
    logic [3:0] rid;
    clr_inputs();
    do_reset();

    // Both channels requesting continuously from reset release: W first, then alternate.
    ARESETN = 1'b0;
    AWVALID_S = 1; ARVALID_S = 1; AWLEN_S = 0; ARLEN_S = 0;
    AWID_S = 4'd6; ARID_S = 4'd10;
    wr_beat = 1; wr_last = 1; rd_beat = 1; BREADY_S = 1;
    @(negedge ACLK);
    ARESETN = 1'b1;
    for (int r = 0; r < 2; r++) begin
      trace.push_back(5'b10000); trace.push_back(5'b01000); trace.push_back(5'b00100);
      trace.push_back(5'b00000);
      trace.push_back(5'b00010); trace.push_back(5'b00001); trace.push_back(5'b00000);
    end
    foreach (trace[i]) begin
      @(negedge ACLK);
      chk("alt_order", 32'({awready_mc, wr_gnt, bvalid_mc, arready_mc, rd_gnt}), 32'(trace[i]));
      chk("alt_excl", 32'(wr_gnt & rd_gnt), 32'd0);
      chk("alt_len_err", 32'(len_err), 32'd0);
    end
    clr_inputs();
    @(negedge ACLK);
    chk_idle("alt_done_idle");

    do_write(4'd5, 8'd3, 1, -1, 2);
    do_read(4'd9, 8'd0, -1);
    do_write(4'($urandom_range(0, 15)), 8'd2, int'($urandom_range(0, 3)), 0, 2);

    for (int t = 0; t < 8; t++) begin
      if ($urandom_range(0, 1) != 0)
        do_write(4'($urandom_range(0, 15)), 8'($urandom_range(0, 15)),
                 int'($urandom_range(0, 3)),
                 ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 15)) : -1, 3);
      else
        do_read(4'($urandom_range(0, 15)), 8'($urandom_range(0, 15)), -1);
    end

    do_write(4'd12, 8'd255, 0, -1, 0);
    rid = 4'($urandom_range(0, 15));
    do_read(rid, 8'd255, 100);
    do_write(4'd3, 8'd1, 0, -1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
